// File: rtl/frame_stream_tx_pkg.sv
// Shared definitions for the frame playback path (frame_stream_tx) and its capture-side twin.
// Holds default geometry, FSM state encodings, the RGB333 field layout and the colour expansion.
// No logic of its own; everything here is constants, types and pure functions.
package frame_stream_tx_pkg;

  // Default frame geometry and memory shape
  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int ADDR_W_DFLT   = 19;
  localparam int PIX_W_DFLT    = 9;

  // Playback FSM encodings, kept as plain 2-bit constants so older tools can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Stored pixel layout {R[2:0],G[2:0],B[2:0]}; the capture writer packs with the same offsets
  localparam int RGB_FIELD_W = 3;
  localparam int RGB_R_LSB   = 6;
  localparam int RGB_G_LSB   = 3;
  localparam int RGB_B_LSB   = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale codes exact: 3'b000 -> 8'h00, 3'b111 -> 8'hFF
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic rgb888_t rgb333_to_888(input logic [8:0] p);
    rgb888_t o;
    o.r = expand3(p[RGB_R_LSB +: RGB_FIELD_W]);
    o.g = expand3(p[RGB_G_LSB +: RGB_FIELD_W]);
    o.b = expand3(p[RGB_B_LSB +: RGB_FIELD_W]);
    return o;
  endfunction

endpackage

// File: rtl/frame_stream_tx_if.sv
// AXI4-Stream video bundle: 24-bit {R8,G8,B8} payload with SOF on tuser and EOL on tlast.
// Pure wiring, no latency.
// tready from the slave gates the transfer; tvalid/payload are owned by the master.
interface frame_stream_tx_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/frame_stream_tx_fifo2.sv
// stream_fifo2: 2-entry register FIFO carrying {tuser,tlast,pixel} between memory and stream.
// Head is visible the cycle after the push; simultaneous push/pop keeps count constant.
// No internal backpressure: the writer must never push when full unless it also pops.
module stream_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage: write into the slot under wr_ptr; slots clear on reset so the stream reads zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
    end else if (push) begin
      if (wr_ptr) slot1 <= din;
      else        slot0 <= din;
      wr_ptr <= ~wr_ptr;
    end
  end

  // Read pointer advances on every pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    rd_ptr <= 1'b0;
    else if (pop) rd_ptr <= ~rd_ptr;
  end

  // Occupancy: push and pop in the same cycle cancel out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/frame_stream_tx.sv
// frame_stream_tx: plays one stored RGB333 frame out as 24-bit AXI4-Stream video per start request.
// Latency: first read the cycle after start is accepted, first tvalid two edges after acceptance.
// Full tready backpressure: reads are issued only while FIFO + in-flight read leaves a free slot.
module frame_stream_tx
  import frame_stream_tx_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int PIX_W    = PIX_W_DFLT
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_add,
  input  logic [PIX_W-1:0]  mem_rd_data,
  frame_stream_tx_if.master m_axis_video
);

  localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int COL_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int ENT_W  = PIX_W + 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_ACTIVE - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_add;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;

  // One read may be in flight; its tags wait here for the data to come back
  logic inflight;
  logic tag_user_q;
  logic tag_last_q;

  logic [ENT_W-1:0] fifo_din;
  logic [ENT_W-1:0] fifo_head;
  logic [1:0]       fifo_count;

  logic       out_vld;
  logic       pop;
  logic [2:0] occ_after_pop;
  logic       rd_issue;
  logic       start_ok;
  logic       last_beat;
  logic       head_user;
  logic       head_last;
  logic [PIX_W-1:0] head_pix;
  rgb888_t    head_rgb;

  assign start_ok = (state == ST_IDLE) && frame_start;

  // A beat leaves the block on the handshake; tvalid itself only looks at FIFO occupancy
  assign out_vld = (fifo_count != 2'd0);
  assign pop     = out_vld && m_axis_video.tready;

  // Slots that will still be claimed after this cycle's pop; a new read needs one free slot
  assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_issue      = (state == ST_FETCH) && (occ_after_pop < 3'd2);

  // Final beat: in DRAIN every read is issued, so an EOL pop of the only remaining entry ends the frame
  assign last_beat = (state == ST_DRAIN) && pop && head_last &&
                     (fifo_count == 2'd1) && !inflight;

  // Frame sequencing: a start only counts in IDLE; the frame ends on the last accepted beat
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (frame_start)                        state <= ST_FETCH;
        ST_FETCH: if (rd_issue && (rd_add == LAST_ADDR))  state <= ST_DRAIN;
        ST_DRAIN: if (last_beat)                          state <= ST_IDLE;
        default:                                          state <= ST_IDLE;
      endcase
    end
  end

  // Read address and raster position advance together, one step per issued read
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      rd_add <= '0;
      col    <= '0;
      line   <= '0;
    end else if (start_ok) begin
      rd_add <= '0;
      col    <= '0;
      line   <= '0;
    end else if (rd_issue) begin
      rd_add <= rd_add + 1'b1;
      if (col == LAST_COL) begin
        col  <= '0;
        line <= line + 1'b1;
      end else begin
        col  <= col + 1'b1;
      end
    end
  end

  // Tags are decided at issue time and ride alongside the read until the data lands
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      inflight   <= 1'b0;
      tag_user_q <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        tag_user_q <= (col == '0) && (line == '0);
        tag_last_q <= (col == LAST_COL);
      end
    end
  end

  // Returning read data is pushed unconditionally; the issue rule guarantees a free slot
  assign fifo_din = {tag_user_q, tag_last_q, mem_rd_data};

  stream_fifo2 #(
    .W (ENT_W)
  ) u_fifo (
    .clk   (Cclk),
    .rstn  (rstn),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign head_user = fifo_head[PIX_W+1];
  assign head_last = fifo_head[PIX_W];
  assign head_pix  = fifo_head[PIX_W-1:0];
  assign head_rgb  = rgb333_to_888(9'(head_pix));

  assign m_axis_video.tvalid = out_vld;
  assign m_axis_video.tdata  = head_rgb;
  assign m_axis_video.tuser  = head_user;
  assign m_axis_video.tlast  = head_last;

  assign mem_rd_en  = rd_issue;
  assign mem_rd_add = rd_add;
  assign busy       = (state != ST_IDLE);
  assign frame_done = last_beat;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx on an 8x4 frame with a 1-cycle RAM holding mem[i] = i.
// Expected beats come from a raster-order model: beat k carries expanded mem[k], tuser at k==0,
// tlast when k mod 8 == 7; a negedge monitor compares every handshake and stall against it.
module tb_frame_stream_tx;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int TOTAL = H * V;
  localparam int AW    = 19;

  logic          Cclk;
  logic          rstn;
  logic          frame_start;
  logic          busy;
  logic          frame_done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_add;
  logic [8:0]    mem_rd_data;

  frame_stream_tx_if vid ();

  frame_stream_tx #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .PIX_W    (9)
  ) dut (
    .Cclk         (Cclk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .busy         (busy),
    .frame_done   (frame_done),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_add   (mem_rd_add),
    .mem_rd_data  (mem_rd_data),
    .m_axis_video (vid.slave)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  // ---------------- checking bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    else             pass_cnt++;
  endtask

  // ---------------- RAM model ----------------
  logic [8:0] mem [0:TOTAL-1];

  always @(posedge Cclk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_add[4:0]];
  end

  task automatic load_identity();
    for (int i = 0; i < TOTAL; i++) mem[i] = 9'(i);
  endtask

  // ---------------- reference colour arithmetic ----------------
  function automatic logic [7:0] exp8(input int c);
    return 8'((c * 32) + (c * 4) + (c / 2));
  endfunction

  function automatic logic [23:0] exp24(input logic [8:0] p);
    int v;
    v = int'(p);
    return {exp8((v / 64) % 8), exp8((v / 8) % 8), exp8(v % 8)};
  endfunction

  // ---------------- tready driver ----------------
  int rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: held low
  initial begin
    vid.tready = 1'b1;
    forever begin
      @(posedge Cclk);
      #1;
      case (rdy_mode)
        0:       vid.tready = 1'b1;
        1:       vid.tready = 1'($urandom_range(0, 1));
        default: vid.tready = 1'b0;
      endcase
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge Cclk);
    cyc++;
  end

  // ---------------- model state / monitor ----------------
  logic        mon_en = 1'b0;
  int          beats, issued, done_cnt, first_cyc, last_cyc;
  logic [31:0] tuser_mask, tlast_mask;
  logic [23:0] got_data [0:2];
  logic        prev_stall, prev_done, hs;
  logic [25:0] prev_pay;

  task automatic model_reset();
    beats      = 0;
    issued     = 0;
    done_cnt   = 0;
    first_cyc  = 0;
    last_cyc   = 0;
    tuser_mask = '0;
    tlast_mask = '0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    for (int i = 0; i < 3; i++) got_data[i] = 'x;
  endtask

  always @(negedge Cclk) begin
    if (mon_en) begin
      hs = vid.tvalid & vid.tready;
      if (prev_stall)
        chk("payload_stable", 32'({vid.tvalid, vid.tuser, vid.tlast, vid.tdata}), 32'({1'b1, prev_pay}));
      if (prev_done) chk("busy_drop_after_done", 32'(busy), 32'd0);
      if (hs) begin
        chk("no_extra_beat", 32'(beats < TOTAL), 32'd1);
        if (beats < TOTAL) begin
          chk($sformatf("beat%0d", beats), 32'({vid.tuser, vid.tlast, vid.tdata}),
              32'({beats == 0, (beats % H) == H - 1, exp24(mem[beats])}));
          if (vid.tuser) tuser_mask[beats] = 1'b1;
          if (vid.tlast) tlast_mask[beats] = 1'b1;
          if (beats < 3) got_data[beats] = vid.tdata;
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      chk("frame_done", 32'(frame_done), 32'(hs && (beats == TOTAL - 1)));
      if (frame_done) done_cnt++;
      if (mem_rd_en) begin
        chk("rd_addr", 32'(mem_rd_add), 32'(issued));
        issued++;
      end
      if (hs) beats++;
      chk("outstanding_le2", 32'((issued - beats) <= 2), 32'd1);
      prev_stall = vid.tvalid & ~vid.tready;
      prev_pay   = {vid.tuser, vid.tlast, vid.tdata};
      prev_done  = frame_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Entered at posedge+1; returns at posedge+1 right after the edge that accepted the start
  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge Cclk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge Cclk);
      #1;
      n++;
    end
    chk({nm, "_no_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_frame_totals(input string nm);
    chk({nm, "_beats"}, 32'(beats), 32'd32);
    chk({nm, "_tuser_mask"}, tuser_mask, 32'h0000_0001);
    chk({nm, "_tlast_mask"}, tlast_mask, 32'h8080_8080);
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Cclk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    logic any_done, any_vld, any_busy;

    load_identity();
    model_reset();
    rstn        = 1'b0;
    frame_start = 1'b0;
    mem_rd_data = '0;
    idle_cycles(3);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_add", 32'(mem_rd_add), 32'd0);
    chk("rst_out", 32'({vid.tvalid, vid.tuser, vid.tlast, vid.tdata}), 32'd0);
    rstn = 1'b1;
    idle_cycles(2);

    // 1: tready high, back-to-back frame with exact latency
    rdy_mode = 0;
    model_reset();
    mon_en = 1'b1;
    pulse_start();
    chk("t1_first_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t1_first_rd_add", 32'(mem_rd_add), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_tvalid_e1", 32'(vid.tvalid), 32'd0);
    idle_cycles(1);
    chk("t1_tvalid_e2", 32'(vid.tvalid), 32'd0);
    idle_cycles(1);
    chk("t1_tvalid_e3", 32'({vid.tvalid, vid.tuser, vid.tdata}), 32'({2'b11, 24'h000000}));
    wait_idle("t1", 200);
    check_frame_totals("t1");
    chk("t1_consecutive", 32'(last_cyc - first_cyc), 32'd31);

    // 2: random backpressure
    rdy_mode = 1;
    model_reset();
    pulse_start();
    wait_idle("t2", 2000);
    check_frame_totals("t2");

    // 3: colour expansion corners
    mem[0] = 9'h1FF;
    mem[1] = 9'h000;
    mem[2] = 9'b100_010_001;
    rdy_mode = 1;
    model_reset();
    pulse_start();
    wait_idle("t3", 2000);
    chk("t3_white", 32'(got_data[0]), 32'h00FF_FFFF);
    chk("t3_black", 32'(got_data[1]), 32'h0000_0000);
    chk("t3_mixed", 32'(got_data[2]), 32'h0092_4924);
    load_identity();

    // 4: start during FETCH is ignored; a later start replays from address 0
    rdy_mode = 0;
    model_reset();
    pulse_start();
    idle_cycles(3);
    pulse_start();
    wait_idle("t4a", 200);
    check_frame_totals("t4a");
    idle_cycles(2);
    model_reset();
    pulse_start();
    chk("t4b_restart_add", 32'({mem_rd_en, mem_rd_add}), 32'({1'b1, 19'd0}));
    wait_idle("t4b", 200);
    check_frame_totals("t4b");

    // 5: reset mid-frame with tready low
    rdy_mode = 0;
    model_reset();
    pulse_start();
    n = 0;
    while (beats < 10 && n < 200) begin
      @(posedge Cclk);
      #1;
      n++;
    end
    chk("t5_reach_beat10", 32'(n < 200), 32'd1);
    rdy_mode = 2;
    @(posedge Cclk);
    #2;
    chk("t5_pre_reset_tvalid", 32'({vid.tready, vid.tvalid}), 32'b01);
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    chk("t5_async_clear", 32'({vid.tvalid, busy, mem_rd_en, frame_done}), 32'd0);
    idle_cycles(3);
    rstn     = 1'b1;
    any_done = 1'b0;
    any_vld  = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Cclk);
      any_done |= frame_done;
      any_vld  |= vid.tvalid;
      any_busy |= busy;
    end
    chk("t5_no_done_after_reset", 32'(any_done), 32'd0);
    chk("t5_no_tvalid_after_reset", 32'(any_vld), 32'd0);
    chk("t5_idle_after_reset", 32'(any_busy), 32'd0);
    @(posedge Cclk);
    #1;
    rdy_mode = 1;
    model_reset();
    mon_en = 1'b1;
    pulse_start();
    wait_idle("t5", 2000);
    check_frame_totals("t5");

    // 6: tready held low -> only two reads, then resume
    rdy_mode = 2;
    idle_cycles(2);
    model_reset();
    pulse_start();
    idle_cycles(100);
    chk("t6_two_reads", 32'(issued), 32'd2);
    chk("t6_head_held", 32'({vid.tvalid, vid.tuser, vid.tdata}), 32'({2'b11, 24'h000000}));
    rdy_mode = 0;
    wait_idle("t6", 300);
    check_frame_totals("t6");
    chk("t6_reads_total", 32'(issued), 32'd32);

    mon_en = 1'b0;
    idle_cycles(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
